// File: rtl/pwm_meas.sv
// PWM duty recovery: times high and period lengths of a 2^W-clock PWM stream and reports duty, bad periods and stuck-low.
// Optional continuous-high reporting is compiled in with PWM_MEAS_STUCK_HI_EN.
module pwm_meas #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] duty,
  output logic         valid,
  output logic         period_err,
  output logic         stuck_lo
);

  localparam int CW = W + 1;
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] FULL    = {1'b1, {W{1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] low_q, low_d;
  logic [W-1:0]  duty_q, duty_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          stuck_q, stuck_d;
  logic          rise, fall;
  logic [CW-1:0] high_m1;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign high_m1 = high_q - ONE;

  // Counters stick at all-ones so a very long phase can never alias to a good period.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    low_d    = low_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    stuck_d  = stuck_q;
    case (state_q)
      SYNC: begin
        if (rise) begin
          state_d  = HIGH;
          period_d = ONE;
          high_d   = ONE;
          stuck_d  = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          low_d    = ONE;
          period_d = sat_inc(period_q);
        end
`ifdef PWM_MEAS_STUCK_HI_EN
        else if (high_q == FULL) begin
          duty_d   = {W{1'b1}};
          valid_d  = 1'b1;
          period_d = ONE;
          high_d   = ONE;
        end
`endif
        else begin
          period_d = sat_inc(period_q);
          high_d   = sat_inc(high_q);
        end
      end
      LOW: begin
        // Edge handling has priority over the stuck-low threshold.
        if (rise) begin
          if (period_q == FULL) begin
            duty_d  = high_m1[W-1:0];
            valid_d = 1'b1;
          end else begin
            perr_d  = 1'b1;
          end
          state_d  = HIGH;
          period_d = ONE;
          high_d   = ONE;
        end else if (low_q == FULL) begin
          stuck_d = 1'b1;
          state_d = SYNC;
        end else begin
          period_d = sat_inc(period_q);
          low_d    = sat_inc(low_q);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= SYNC;
      period_q <= '0;
      high_q   <= '0;
      low_q    <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      low_q    <= low_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      stuck_q  <= stuck_d;
    end
  end

  assign duty       = duty_q;
  assign valid      = valid_q;
  assign period_err = perr_q;
  assign stuck_lo   = stuck_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: drives PWM waveforms cycle by cycle and checks duty/valid/period_err/stuck_lo.
module tb_pwm_meas;
  localparam int W = 11;
  localparam int P = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwm_in;
  logic [W-1:0] duty;
  logic         valid, period_err, stuck_lo;

  int errors = 0, checks = 0;
  int cyc = 0, nvalid = 0, nperr = 0, nboth = 0, last_v = 0, gap = 0;
  int v0, e0;
  logic seen;

  pwm_meas #(.W(W)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty),
    .valid(valid), .period_err(period_err), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      nvalid++;
      gap = cyc - last_v;
      last_v = cyc;
    end
    if (period_err) nperr++;
    if (valid && period_err) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic periods(input int h, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, P - h);
    end
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_perr", 32'(period_err), 0);
    chk("rst_stuck", 32'(stuck_lo), 0);
    rst = 1'b0;

    // duty 0: first rise only starts timing, the next four report
    v0 = nvalid; e0 = nperr;
    periods(1, 5);
    chk("d0_nvalid", 32'(nvalid - v0), 4);
    chk("d0_duty", 32'(duty), 32'h000);
    chk("d0_nperr", 32'(nperr - e0), 0);
    chk("d0_stuck", 32'(stuck_lo), 0);
    chk("d0_gap", 32'(gap), P);

    v0 = nvalid; e0 = nperr;
    periods(256, 3);
    chk("dff_nvalid", 32'(nvalid - v0), 3);
    chk("dff_duty", 32'(duty), 32'h0FF);
    chk("dff_nperr", 32'(nperr - e0), 0);
    chk("dff_gap", 32'(gap), P);

    periods(1025, 1);
    chk("d400_prev", 32'(duty), 32'h0FF);
    drive(1'b1, 1025);
    chk("d400_duty", 32'(duty), 32'h400);

    // stuck low: visible 2051 negedges after the line drops
    v0 = nvalid; e0 = nperr;
    drive(1'b0, 1);
    seen = 1'b0;
    repeat (2050) begin
      @(negedge clk);
      if (stuck_lo) seen = 1'b1;
    end
    chk("stuck_early", 32'(seen), 0);
    @(negedge clk);
    chk("stuck_set", 32'(stuck_lo), 1);
    drive(1'b0, 948);
    chk("stuck_hold", 32'(stuck_lo), 1);
    chk("stuck_nvalid", 32'(nvalid - v0), 0);
    chk("stuck_nperr", 32'(nperr - e0), 0);

    v0 = nvalid; e0 = nperr;
    drive(1'b1, 10);
    chk("stuck_clear", 32'(stuck_lo), 0);
    drive(1'b1, 246);
    drive(1'b0, P - 256);
    periods(256, 2);
    chk("recov_nvalid", 32'(nvalid - v0), 2);
    chk("recov_nperr", 32'(nperr - e0), 0);
    chk("recov_duty", 32'(duty), 32'h0FF);
    chk("recov_gap", 32'(gap), P);

    // 1000-clock square wave: the first rise closes a good period, the rest are errors
    v0 = nvalid; e0 = nperr;
    repeat (4) begin
      drive(1'b1, 500);
      drive(1'b0, 500);
    end
    chk("sq_nvalid", 32'(nvalid - v0), 1);
    chk("sq_nperr", 32'(nperr - e0), 3);
    chk("sq_duty", 32'(duty), 32'h0FF);

    v0 = nvalid; e0 = nperr;
    drive(1'b1, 6244);
    chk("hi_nperr", 32'(nperr - e0), 1);
`ifdef PWM_MEAS_STUCK_HI_EN
    chk("hi_nvalid", 32'(nvalid - v0), 3);
    chk("hi_duty", 32'(duty), 32'h7FF);
`else
    chk("hi_nvalid", 32'(nvalid - v0), 0);
    chk("hi_duty", 32'(duty), 32'h0FF);
`endif
    drive(1'b0, 100);

    // async reset mid-high; the line is high at release so a truncated period follows
    drive(1'b1, 50);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty", 32'(duty), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_perr", 32'(period_err), 0);
    chk("arst_stuck", 32'(stuck_lo), 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = nvalid; e0 = nperr;
    drive(1'b1, 205);
    drive(1'b0, P - 256);
    periods(256, 1);
    chk("post_nvalid0", 32'(nvalid - v0), 0);
    chk("post_duty0", 32'(duty), 0);
    chk("post_nperr", 32'(nperr - e0), 1);
    periods(256, 1);
    chk("post_nvalid1", 32'(nvalid - v0), 1);
    chk("post_duty1", 32'(duty), 32'h0FF);

    chk("valid_perr_overlap", 32'(nboth), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
